bolge_tarayici: RTL and testbench
=================================

Name: bolge_tarayici

Overview:
- Sequential stimulus generator and response checker for the combinational region decoder, which maps {Y, G[1:0], R[1:0]} to B[1:0].
- On a start request it drives every one of the 32 input codes in order and samples the decoder's B response for each code.
- It counts the codes whose response equals a requested target mask, records the first matching code, and reports the result with a done handshake.
- Used as the self-check / characterisation driver on the other side of the decoder interface.

Parameters:
- RESP_LAT, 0, cycles between a code appearing on Y/G/R outputs and its B response being valid on b_in (0 = decoder is purely combinational; legal range 0..3).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a sweep; accepted only in IDLE
- target  input  2  B value counted as a match; captured when start is accepted
- Y  output  1  code bit 4 driven to the decoder
- G  output  2  code bits 3:2 driven to the decoder
- R  output  2  code bits 1:0 driven to the decoder
- b_in  input  2  decoder response B
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse when results are valid
- match_cnt  output  6  number of matching codes, range 0..32
- first_idx  output  5  {Y,G,R} index of the first match; 0 if none
- found  output  1  high if match_cnt > 0

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; Y=0, G=0, R=0, busy=0, done=0, match_cnt=0, first_idx=0, found=0; the internal index and the latency pipeline clear.
- Code index idx[4:0] = {Y, G[1:0], R[1:0]}. The Y/G/R outputs are registered and sweep from 0 to 31, ascending.
- FSM states:
  - IDLE: Y/G/R hold 0.
    - If start=1: capture target, clear match_cnt/first_idx/found, set busy=1, drive idx=0, go to SWEEP.
  - SWEEP: one code per cycle.
    - idx increments each cycle.
    - After idx=31 is driven, go to DRAIN. The outputs hold 31 (no wrap to 0 during a sweep).
  - DRAIN: lasts RESP_LAT cycles (skipped when RESP_LAT=0), so the last responses can be sampled.
  - DONE: one cycle.
    - done=1, busy=0, results stable.
    - Return to IDLE; Y/G/R return to 0.
- Sampling: a tag pipeline of depth RESP_LAT carries {valid, idx}. In the cycle a tag emerges valid, b_in is compared with the captured target:
  - On equality, match_cnt increments.
  - If found was 0, first_idx is set to the tag idx and found is set to 1.
- Exactly 32 samples are taken per sweep. Total start-to-done latency is 33+RESP_LAT cycles.
- match_cnt is 6 bits so that 32 matches do not overflow. Results hold after DONE until the next accepted start.
- start while busy: ignored, with no restart and no effect on target.
- start in the DONE cycle: ignored. It is accepted on the next IDLE cycle only if it is still asserted.
- target changing mid-sweep: no effect; the captured value is used.
- rst_n asserted mid-sweep: immediate abort to reset values. No done pulse is generated.

Decomposition:
- Shared package/header: state encodings (IDLE, SWEEP, DRAIN, DONE), CODE_W=5, CNT_W=6, NUM_CODES=32.
- One natural sub-module, bolge_gecikme: a RESP_LAT-deep {valid, idx} tag delay line with asynchronous active-low reset. At RESP_LAT=0 it is a pass-through.
- The top level holds the FSM, the index counter, and the match/first-match accumulation.

Test Plan:
- Reset mid-sweep: pulse rst_n low at idx=10 -> all outputs at reset values immediately, no done; the next start performs a full sweep correctly.
- Target=2'b11, RESP_LAT=0, decoder attached -> done 33 cycles after start, match_cnt=26, first_idx=0, found=1.
- Target=2'b00 -> match_cnt=2, first_idx=20 (Y=1, G=01, R=00).
- Target=2'b01 -> match_cnt=2, first_idx=21; target=2'b10 -> match_cnt=2, first_idx=22. Totals over all four targets sum to 32.
- RESP_LAT=2 with a 2-stage delayed decoder model, target=2'b11 -> match_cnt=26, done 35 cycles after start.
- start re-pulsed at cycles 5 and 20 of a sweep, plus target changed mid-sweep -> results identical to an undisturbed sweep; b_in forced to 2'b00 with target=2'b11 -> match_cnt=0, found=0, first_idx=0.

Source files
------------

// File: rtl/bolge_tarayici_pkg.sv
// rtl/bolge_tarayici_pkg.sv - shared widths and FSM states for the region sweep driver
package bolge_tarayici_pkg;
  localparam int CODE_W    = 5;
  localparam int CNT_W     = 6;
  localparam int NUM_CODES = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/bolge_gecikme.sv
// rtl/bolge_gecikme.sv - RESP_LAT-deep {valid, idx} tag delay line
module bolge_gecikme
  import bolge_tarayici_pkg::*;
#(
  parameter int RESP_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_v,
  input  logic [CODE_W-1:0] in_idx,
  output logic              out_v,
  output logic [CODE_W-1:0] out_idx
);
  generate
    if (RESP_LAT == 0) begin : g_pass
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign out_v      = in_v;
      assign out_idx    = in_idx;
    end else begin : g_pipe
      logic              v_q   [RESP_LAT];
      logic [CODE_W-1:0] idx_q [RESP_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RESP_LAT; i++) begin
            v_q[i]   <= 1'b0;
            idx_q[i] <= '0;
          end
        end else begin
          v_q[0]   <= in_v;
          idx_q[0] <= in_idx;
          for (int i = 1; i < RESP_LAT; i++) begin
            v_q[i]   <= v_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign out_v   = v_q[RESP_LAT-1];
      assign out_idx = idx_q[RESP_LAT-1];
    end
  endgenerate
endmodule

// File: rtl/bolge_tarayici.sv
// rtl/bolge_tarayici.sv - sweeps all 32 {Y,G,R} codes and counts B responses equal to target
module bolge_tarayici
  import bolge_tarayici_pkg::*;
#(
  parameter int RESP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       target,
  output logic             Y,
  output logic [1:0]       G,
  output logic [1:0]       R,
  input  logic [1:0]       b_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CODE_W-1:0] first_idx,
  output logic             found
);
  localparam logic [CODE_W-1:0] LAST_IDX   = CODE_W'(NUM_CODES - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'((RESP_LAT == 0) ? 0 : RESP_LAT - 1);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] idx;
  logic [1:0]        tgt;
  logic [1:0]        drain_cnt;
  logic              tag_v;
  logic [CODE_W-1:0] tag_idx;

  bolge_gecikme #(.RESP_LAT(RESP_LAT)) u_gecikme (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_v    (state_q == SWEEP),
    .in_idx  (idx),
    .out_v   (tag_v),
    .out_idx (tag_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: if (idx == LAST_IDX) state_d = (RESP_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (drain_cnt == DRAIN_LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      tgt       <= '0;
      drain_cnt <= '0;
      match_cnt <= '0;
      first_idx <= '0;
      found     <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        tgt       <= target;
        idx       <= '0;
        match_cnt <= '0;
        first_idx <= '0;
        found     <= 1'b0;
      end
    end else begin
      case (state_q)
        SWEEP: begin
          drain_cnt <= '0;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        default: idx <= '0;
      endcase
      // Samples are aligned to the delayed tag, not to the code currently driven.
      if (tag_v && (b_in == tgt)) begin
        match_cnt <= match_cnt + 1'b1;
        if (!found) begin
          first_idx <= tag_idx;
          found     <= 1'b1;
        end
      end
    end
  end

  assign Y    = idx[4];
  assign G    = idx[3:2];
  assign R    = idx[1:0];
  assign busy = (state_q == SWEEP) || (state_q == DRAIN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_bolge_tarayici.sv
// tb/tb_bolge_tarayici.sv - self-checking bench for bolge_tarayici at RESP_LAT 0 and 2
module tb_bolge_tarayici;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] target = 2'b00;
  logic       b_force = 1'b0;

  logic       y0, y2, busy0, busy2, done0, done2, fd0, fd2;
  logic [1:0] g0, r0, g2, r2, b0, b2, d1, d2;
  logic [5:0] cnt0, cnt2;
  logic [4:0] fi0, fi2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Region decoder the DUT is wired to: only Y=1, G in {01,10}, R!=11 fall outside region 11.
  function automatic logic [1:0] dec(input logic [4:0] c);
    if (c[4] && (c[3:2] == 2'b01 || c[3:2] == 2'b10) && c[1:0] != 2'b11) return c[1:0];
    return 2'b11;
  endfunction

  function automatic int ref_cnt(input logic [1:0] t);
    int n = 0;
    for (int i = 0; i < 32; i++) if (dec(5'(i)) == t) n++;
    return n;
  endfunction

  function automatic int ref_first(input logic [1:0] t);
    for (int i = 0; i < 32; i++) if (dec(5'(i)) == t) return i;
    return 0;
  endfunction

  assign b0 = b_force ? 2'b00 : dec({y0, g0, r0});
  always @(posedge clk) begin
    d1 <= dec({y2, g2, r2});
    d2 <= d1;
  end
  assign b2 = d2;

  bolge_tarayici #(.RESP_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .Y(y0), .G(g0), .R(r0), .b_in(b0), .busy(busy0), .done(done0),
    .match_cnt(cnt0), .first_idx(fi0), .found(fd0)
  );

  bolge_tarayici #(.RESP_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .Y(y2), .G(g2), .R(r2), .b_in(b2), .busy(busy2), .done(done2),
    .match_cnt(cnt2), .first_idx(fi2), .found(fd2)
  );

  int         lat0, lat2, rc0, rc2, rfd0, rfd2, rbusy1;
  logic [4:0] rfi0, rfi2;

  task automatic run_sweep(input logic [1:0] t, input bit disturb);
    lat0 = -1; lat2 = -1; rbusy1 = 0;
    @(negedge clk);
    target = t;
    start  = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = disturb && (k == 5 || k == 20);
      if (disturb && k == 10) target = ~t;
      if (k == 1) rbusy1 = int'(busy0 & busy2);
      if (done0 && lat0 < 0) begin
        lat0 = k; rc0 = int'(cnt0); rfi0 = fi0; rfd0 = int'(fd0);
      end
      if (done2 && lat2 < 0) begin
        lat2 = k; rc2 = int'(cnt2); rfi2 = fi2; rfd2 = int'(fd2);
      end
      if (lat0 > 0 && lat2 > 0) break;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({y0, g0, r0, busy0, done0, cnt0, fi0, fd0} !== 19'd0) begin
      errors++;
      $display("FAIL reset_u0: got y%b g%b r%b busy%b done%b cnt%0d fi%0d fd%b, want all 0",
               y0, g0, r0, busy0, done0, cnt0, fi0, fd0);
    end
    checks++;
    if ({y2, g2, r2, busy2, done2, cnt2, fi2, fd2} !== 19'd0) begin
      errors++;
      $display("FAIL reset_u2: got nonzero outputs cnt%0d fi%0d busy%b", cnt2, fi2, busy2);
    end
  endtask

  task automatic test_targets;
    int total = 0;
    logic [1:0] order [4];
    for (int i = 0; i < 4; i++) order[i] = 2'(i);
    for (int i = 0; i < 4; i++) begin
      int j = $urandom_range(3);
      logic [1:0] tmp = order[i];
      order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] t = order[i];
      run_sweep(t, 1'b0);
      total += rc0;
      checks++;
      if (lat0 != 33) begin errors++; $display("FAIL lat0_t%0d: got %0d want 33", t, lat0); end
      checks++;
      if (rc0 != ref_cnt(t) || int'(rfi0) != ref_first(t) || rfd0 != int'(ref_cnt(t) > 0)) begin
        errors++;
        $display("FAIL result0_t%0d: got cnt%0d fi%0d fd%0d want cnt%0d fi%0d fd%0d",
                 t, rc0, rfi0, rfd0, ref_cnt(t), ref_first(t), int'(ref_cnt(t) > 0));
      end
      checks++;
      if (lat2 != 35) begin errors++; $display("FAIL lat2_t%0d: got %0d want 35", t, lat2); end
      checks++;
      if (rc2 != ref_cnt(t) || int'(rfi2) != ref_first(t) || rfd2 != int'(ref_cnt(t) > 0)) begin
        errors++;
        $display("FAIL result2_t%0d: got cnt%0d fi%0d want cnt%0d fi%0d",
                 t, rc2, rfi2, ref_cnt(t), ref_first(t));
      end
      checks++;
      if (rbusy1 != 1) begin errors++; $display("FAIL busy_t%0d: got %0d want 1", t, rbusy1); end
    end
    checks++;
    if (total != 32) begin errors++; $display("FAIL total: got %0d want 32", total); end
    checks++;
    if (cnt0 !== 6'(ref_cnt(order[3])) || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL hold: got cnt%0d busy%b done%b want cnt%0d busy0 done0",
               cnt0, busy0, done0, ref_cnt(order[3]));
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] t = 2'($urandom_range(3));
    run_sweep(t, 1'b1);
    checks++;
    if (lat0 != 33 || rc0 != ref_cnt(t) || int'(rfi0) != ref_first(t)) begin
      errors++;
      $display("FAIL disturb0_t%0d: got lat%0d cnt%0d fi%0d want lat33 cnt%0d fi%0d",
               t, lat0, rc0, rfi0, ref_cnt(t), ref_first(t));
    end
    checks++;
    if (lat2 != 35 || rc2 != ref_cnt(t) || int'(rfi2) != ref_first(t)) begin
      errors++;
      $display("FAIL disturb2_t%0d: got lat%0d cnt%0d fi%0d want lat35 cnt%0d fi%0d",
               t, lat2, rc2, rfi2, ref_cnt(t), ref_first(t));
    end
  endtask

  task automatic test_force;
    b_force = 1'b1;
    run_sweep(2'b11, 1'b0);
    b_force = 1'b0;
    checks++;
    if (lat0 != 33 || rc0 != 0 || rfd0 != 0 || rfi0 != 5'd0) begin
      errors++;
      $display("FAIL force: got lat%0d cnt%0d fd%0d fi%0d want lat33 cnt0 fd0 fi0",
               lat0, rc0, rfd0, rfi0);
    end
  endtask

  task automatic test_midreset;
    bit seen = 0;
    bit saw_done = 0;
    @(negedge clk);
    target = 2'b11;
    start  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done0 || done2) saw_done = 1;
      if ({y0, g0, r0} == 5'd10) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midreset_reach: idx 10 not observed, want seen"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({y0, g0, r0, busy0, done0, cnt0, fi0, fd0} !== 19'd0 ||
        {y2, g2, r2, busy2, done2, cnt2, fi2, fd2} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_now: got idx%0d busy%b cnt%0d / idx%0d busy%b cnt%0d, want 0",
               {y0, g0, r0}, busy0, cnt0, {y2, g2, r2}, busy2, cnt2);
    end
    repeat (3) begin
      @(negedge clk);
      if (done0 || done2) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done0 || done2) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midreset_done: got done pulse, want none"); end
    run_sweep(2'b11, 1'b0);
    checks++;
    if (lat0 != 33 || rc0 != 26 || rfi0 != 5'd0 || rfd0 != 1 || lat2 != 35 || rc2 != 26) begin
      errors++;
      $display("FAIL midreset_after: got lat%0d cnt%0d fi%0d fd%0d lat2 %0d cnt2 %0d want 33 26 0 1 35 26",
               lat0, rc0, rfi0, rfd0, lat2, rc2);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_targets;
    test_back_to_back;
    test_force;
    test_midreset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
